// File: rtl/apb_cfg_master_if.sv
// ----------------------------------------------------------------------------
// apb_cfg_master_if
//
// Bundles every non-clock/reset signal of apb_cfg_master:
//   - burst command channel   : cmd_valid, cmd_ready, cmd_write, cmd_addr, cmd_len
//   - write-data stream       : wd_valid, wd_ready, wd_data
//   - per-transfer response   : rsp_valid, rsp_data, rsp_last, rsp_err
//   - APB initiator signals   : PSEL, PENABLE, PWRITE, PADDR, PWDATA, PREADY, PRDATA
//   - status                  : busy
//
// Modports:
//   master : the view of apb_cfg_master (accepts commands, drives APB).
//   slave  : the view of the surroundings (issues commands, models the APB
//            completer and consumes responses).
// ----------------------------------------------------------------------------
interface apb_cfg_master_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32
);
    // Burst command
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [ADDR_WIDTH-1:0] cmd_len;

    // Write-data stream
    logic                  wd_valid;
    logic                  wd_ready;
    logic [DATA_WIDTH-1:0] wd_data;

    // Response (no backpressure)
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_last;
    logic                  rsp_err;

    // APB
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic                  PREADY;
    logic [DATA_WIDTH-1:0] PRDATA;

    // Status
    logic                  busy;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wd_valid, wd_data,
        input  PREADY, PRDATA,
        output cmd_ready, wd_ready,
        output rsp_valid, rsp_data, rsp_last, rsp_err,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output busy
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wd_valid, wd_data,
        output PREADY, PRDATA,
        input  cmd_ready, wd_ready,
        input  rsp_valid, rsp_data, rsp_last, rsp_err,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  busy
    );
endinterface

// File: rtl/apb_cfg_master.sv
// ----------------------------------------------------------------------------
// apb_cfg_master
//
// Turns a burst command (address, transfer count = cmd_len+1, direction) into
// a sequence of APB transfers at consecutive addresses (wrapping modulo
// 2^ADDR_WIDTH). Write bursts consume one word of the wd_* stream per
// transfer; every completed transfer produces a one-cycle response pulse.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous, active-low reset
//   bus    : apb_cfg_master_if.master
//              cmd_*   burst command in (cmd_ready high only in IDLE)
//              wd_*    write-data stream in (wd_ready high only in WDATA)
//              rsp_*   per-transfer response out, rsp_last on final transfer
//              P*      APB initiator signals
//              busy    high whenever the FSM is not IDLE
//
// Parameters:
//   ADDR_WIDTH : APB address width, also the width of cmd_len
//   DATA_WIDTH : APB data width
//   TIMEOUT    : ACCESS wait cycles tolerated before aborting (timeout build)
//
// Build option:
//   APB_TIMEOUT_EN : when defined, an ACCESS phase that waits TIMEOUT cycles
//                    without PREADY is aborted with an error response and the
//                    rest of the burst is dropped. When undefined, ACCESS
//                    waits forever and rsp_err is constant 0.
//
// All outputs except cmd_ready, wd_ready and busy come straight from flops.
// ----------------------------------------------------------------------------
module apb_cfg_master #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    apb_cfg_master_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WDATA  = 2'd1,
        SETUP  = 2'd2,
        ACCESS = 2'd3
    } state_t;

    // A zero timeout would abort before the completer could ever answer.
    if (TIMEOUT < 1) begin : g_timeout_check
        $error("apb_cfg_master: TIMEOUT must be at least 1");
    end

    state_t                state_q,     state_d;
    logic                  psel_q,      psel_d;
    logic                  penable_q,   penable_d;
    logic                  pwrite_q,    pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q,     paddr_d;   // doubles as the burst address register
    logic [DATA_WIDTH-1:0] pwdata_q,    pwdata_d;
    logic [ADDR_WIDTH-1:0] rem_q,       rem_d;     // transfers still to do after the current one
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q,  rsp_data_d;
    logic                  rsp_last_q,  rsp_last_d;

`ifdef APB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0]      tmo_q,       tmo_d;     // ACCESS cycles seen with PREADY low
    logic                  rsp_err_q,   rsp_err_d;
`endif

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rem_d       = rem_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_last_d  = rsp_last_q;
`ifdef APB_TIMEOUT_EN
        tmo_d       = tmo_q;
        rsp_err_d   = rsp_err_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    paddr_d  = bus.cmd_addr;
                    rem_d    = bus.cmd_len;
                    pwrite_d = bus.cmd_write;
                    if (bus.cmd_write) begin
                        state_d = WDATA;
                    end else begin
                        state_d = SETUP;
                        psel_d  = 1'b1;
                    end
                end
            end

            WDATA: begin
                // PWDATA is only loaded here, so it stays put through SETUP/ACCESS.
                if (bus.wd_valid) begin
                    pwdata_d = bus.wd_data;
                    state_d  = SETUP;
                    psel_d   = 1'b1;
                end
            end

            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
                tmo_d     = '0;
`endif
            end

            ACCESS: begin
                if (bus.PREADY) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = pwrite_q ? '0 : bus.PRDATA;
                    rsp_last_d  = (rem_q == '0);
`ifdef APB_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
`endif
                    penable_d   = 1'b0;
                    if (rem_q != '0) begin
                        // Address wraps naturally at 2^ADDR_WIDTH.
                        paddr_d = paddr_q + ADDR_WIDTH'(1);
                        rem_d   = rem_q - ADDR_WIDTH'(1);
                        if (pwrite_q) begin
                            state_d = WDATA;
                            psel_d  = 1'b0;
                        end else begin
                            // Going straight to SETUP keeps PSEL high and gives
                            // one read per two cycles.
                            state_d = SETUP;
                            psel_d  = 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                        psel_d  = 1'b0;
                    end
                end
`ifdef APB_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th wait cycle: abandon the burst.
                    state_d     = IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rem_d       = '0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_last_d  = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
`endif
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rem_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b0;
`ifdef APB_TIMEOUT_EN
            tmo_q       <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rem_q       <= rem_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_last_q  <= rsp_last_d;
`ifdef APB_TIMEOUT_EN
            tmo_q       <= tmo_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.wd_ready  = (state_q == WDATA);
    assign bus.busy      = (state_q != IDLE);

    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_last  = rsp_last_q;
`ifdef APB_TIMEOUT_EN
    assign bus.rsp_err   = rsp_err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_apb_cfg_master.sv
// ----------------------------------------------------------------------------
// tb_apb_cfg_master
//
// Drives random and directed bursts into apb_cfg_master, plays the APB
// completer from a memory array, and compares every transfer and response
// against a memory-level reference model of the burst rules.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_apb_cfg_master;

    localparam int AW  = 7;
    localparam int DW  = 32;
    localparam int TMO = 16;

    typedef struct packed {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } xfer_t;

    typedef struct packed {
        logic          err;
        logic          last;
        logic [DW-1:0] d;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n;

    apb_cfg_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_cfg_master #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Completer memory (written by DUT transfers) and reference memory (written by the model)
    logic [DW-1:0] slave_mem [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem   [0:(1<<AW)-1];
    logic [DW-1:0] last_pwdata;

    xfer_t xfer_q[$];
    int    xfer_cyc_q[$];
    rsp_t  rsp_q[$];

    int forced_waits = -1;   // >=0: fixed wait count per transfer, else random
    int max_waits    = 2;
    bit stuck        = 1'b0; // PREADY never rises
    int cyc          = 0;

    // APB completer + response collector, acting at every falling edge
    initial begin : apb_slave
        logic [AW-1:0] s_addr;
        logic          s_write;
        logic [DW-1:0] s_wdata;
        int            waits_left;
        s_addr     = '0;
        s_write    = 1'b0;
        s_wdata    = '0;
        waits_left = 0;
        bus.PREADY = 1'b0;
        bus.PRDATA = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.rsp_valid)
                rsp_q.push_back({bus.rsp_err, bus.rsp_last, bus.rsp_data});
            if (bus.PSEL && !bus.PENABLE) begin
                s_addr     = bus.PADDR;
                s_write    = bus.PWRITE;
                s_wdata    = bus.PWDATA;
                waits_left = (forced_waits >= 0) ? forced_waits : int'($urandom_range(max_waits, 0));
                bus.PREADY = 1'b0;
                bus.PRDATA = $urandom;
            end else if (bus.PSEL && bus.PENABLE) begin
                chk("paddr_stable",  64'(bus.PADDR),  64'(s_addr));
                chk("pwrite_stable", 64'(bus.PWRITE), 64'(s_write));
                chk("pwdata_stable", 64'(bus.PWDATA), 64'(s_wdata));
                if (!stuck && waits_left == 0) begin
                    bus.PREADY = 1'b1;
                    bus.PRDATA = bus.PWRITE ? DW'($urandom) : slave_mem[bus.PADDR];
                    xfer_q.push_back({bus.PWRITE, bus.PADDR, bus.PWDATA});
                    xfer_cyc_q.push_back(cyc);
                    if (bus.PWRITE) slave_mem[bus.PADDR] = bus.PWDATA;
                end else begin
                    bus.PREADY = 1'b0;
                    bus.PRDATA = $urandom;
                    if (waits_left > 0) waits_left--;
                end
            end else begin
                bus.PREADY = 1'b0;
                bus.PRDATA = $urandom;
            end
        end
    end

    task automatic wait_cmd_ready();
        int n;
        n = 0;
        while (!bus.cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready", 64'(bus.cmd_ready), 64'(1));
    endtask

    // One complete burst; the model derives the expected transfers and responses
    task automatic run_burst(input logic wr, input logic [AW-1:0] addr, input logic [AW-1:0] len,
                             input int stall_idx, input int stall_cyc);
        xfer_t         exp_x[$];
        rsp_t          exp_r[$];
        logic [DW-1:0] words[$];
        logic [AW-1:0] a;
        logic [DW-1:0] w;
        int            n;
        int            nx;
        nx = int'(len) + 1;
        for (int i = 0; i < nx; i++) begin
            a = addr + AW'(i);
            w = $urandom;
            words.push_back(w);
            if (wr) begin
                exp_x.push_back({1'b1, a, w});
                exp_r.push_back({1'b0, (i == nx - 1), DW'(0)});
                ref_mem[a]  = w;
                last_pwdata = w;
            end else begin
                exp_x.push_back({1'b0, a, last_pwdata});
                exp_r.push_back({1'b0, (i == nx - 1), ref_mem[a]});
            end
        end

        rsp_q.delete();
        xfer_q.delete();
        xfer_cyc_q.delete();
        wait_cmd_ready();
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_len   = len;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'($urandom);
        bus.cmd_addr  = AW'($urandom);
        bus.cmd_len   = AW'($urandom);

        if (wr) begin
            for (int i = 0; i < nx; i++) begin
                n = 0;
                while (!bus.wd_ready && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                chk("wd_ready", 64'(bus.wd_ready), 64'(1));
                if (i == stall_idx) begin
                    for (int s = 0; s < stall_cyc; s++) begin
                        @(negedge clk);
                        chk("wdata_hold", 64'({bus.wd_ready, bus.busy, bus.PSEL}), 64'(3'b110));
                    end
                end
                bus.wd_valid = 1'b1;
                bus.wd_data  = words[i];
                @(negedge clk);
                bus.wd_valid = 1'b0;
                bus.wd_data  = $urandom;
            end
        end

        n = 0;
        while (bus.busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("burst_done", 64'(bus.busy), 64'(0));
        @(negedge clk);

        chk("rsp_count",  64'(rsp_q.size()),  64'(nx));
        chk("xfer_count", 64'(xfer_q.size()), 64'(nx));
        for (int i = 0; i < nx; i++) begin
            if (i < rsp_q.size())
                chk($sformatf("rsp[%0d]", i), 64'(rsp_q[i]), 64'(exp_r[i]));
            if (i < xfer_q.size())
                chk($sformatf("xfer[%0d]", i), 64'(xfer_q[i]), 64'(exp_x[i]));
            if (!wr && forced_waits == 0 && i > 0 && i < xfer_cyc_q.size())
                chk("b2b_read_gap", 64'(xfer_cyc_q[i] - xfer_cyc_q[i-1]), 64'(2));
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        int acc;
        logic [AW-1:0] r_len;

        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.wd_valid  = 1'b0;
        bus.wd_data   = '0;
        for (int i = 0; i < (1 << AW); i++) begin
            slave_mem[i] = $urandom;
            ref_mem[i]   = slave_mem[i];
        end
        last_pwdata = '0;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_apb_ctl", 64'({bus.PSEL, bus.PENABLE, bus.PWRITE}), 64'(0));
        chk("rst_paddr",   64'(bus.PADDR),  64'(0));
        chk("rst_pwdata",  64'(bus.PWDATA), 64'(0));
        chk("rst_rsp",     64'({bus.rsp_valid, bus.rsp_last, bus.rsp_err}), 64'(0));
        chk("rst_rdata",   64'(bus.rsp_data), 64'(0));
        chk("rst_hs",      64'({bus.cmd_ready, bus.wd_ready, bus.busy}), 64'(3'b100));

        // Single read with exact cycle timing; a command while busy is ignored
        slave_mem[5]  = 32'h000F_FF76;
        ref_mem[5]    = 32'h000F_FF76;
        forced_waits  = 0;
        rsp_q.delete();
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 7'h05;
        bus.cmd_len   = 7'h00;
        @(negedge clk);
        chk("c1_setup", 64'({bus.PSEL, bus.PENABLE, bus.busy, bus.cmd_ready}), 64'(4'b1010));
        chk("c1_paddr", 64'(bus.PADDR), 64'(7'h05));
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 7'h33;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("c2_access", 64'({bus.PSEL, bus.PENABLE, bus.PWRITE}), 64'(3'b110));
        chk("c2_paddr",  64'(bus.PADDR), 64'(7'h05));
        @(negedge clk);
        chk("c3_rsp",  64'({bus.rsp_valid, bus.rsp_last, bus.rsp_err, bus.busy, bus.PSEL}), 64'(5'b11000));
        chk("c3_data", 64'(bus.rsp_data), 64'(32'h000F_FF76));
        @(negedge clk);
        chk("c4_pulse", 64'({bus.rsp_valid, bus.busy}), 64'(0));

        // Write burst 0x48..0x4C with a 3-cycle stall on the third word
        forced_waits = -1;
        max_waits    = 2;
        run_burst(1'b1, 7'h48, 7'd4, 2, 3);
        // Read it back, back-to-back with no waits
        forced_waits = 0;
        run_burst(1'b0, 7'h48, 7'd4, -1, 0);
        // Read burst across the address wrap
        run_burst(1'b0, 7'h7E, 7'd2, -1, 0);
        // Three wait cycles per transfer
        forced_waits = 3;
        run_burst(1'b1, 7'h10, 7'd0, -1, 0);
        run_burst(1'b0, 7'h10, 7'd0, -1, 0);

        // Random bursts
        forced_waits = -1;
        for (int k = 0; k < 24; k++) begin
            r_len = AW'($urandom_range(7, 0));
            run_burst(1'($urandom), AW'($urandom), r_len,
                      int'($urandom_range(int'(r_len), 0)), int'($urandom_range(3, 0)));
        end

`ifdef APB_TIMEOUT_EN
        // PREADY stuck low: abort after TMO wait cycles
        stuck = 1'b1;
        wait_cmd_ready();
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 7'h20;
        bus.cmd_len   = 7'd3;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        n = 0;
        while (!bus.PENABLE && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_access", 64'(bus.PENABLE), 64'(1));
        acc = 0;
        while (bus.PENABLE && acc < 40) begin
            acc++;
            @(negedge clk);
        end
        chk("tmo_wait_cycles", 64'(acc), 64'(TMO));
        chk("tmo_rsp", 64'({bus.rsp_valid, bus.rsp_err, bus.rsp_last, bus.PSEL, bus.PENABLE, bus.busy}),
            64'(6'b111000));
        chk("tmo_rdata", 64'(bus.rsp_data), 64'(0));
        stuck = 1'b0;
        @(negedge clk);
        run_burst(1'b0, 7'h20, 7'd1, -1, 0);
`endif

        // Reset in the middle of an ACCESS phase of a 4-word burst
        forced_waits = 50;
        wait_cmd_ready();
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 7'h30;
        bus.cmd_len   = 7'd3;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        n = 0;
        while (!bus.PENABLE && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_pre_access", 64'(bus.PENABLE), 64'(1));
        rsp_q.delete();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_drop", 64'({bus.PSEL, bus.PENABLE}), 64'(0));
        repeat (2) begin
            @(negedge clk);
            chk("rst_no_rsp", 64'(bus.rsp_valid), 64'(0));
        end
        rst_n       = 1'b1;
        last_pwdata = '0;
        @(negedge clk);
        chk("rst_release", 64'({bus.cmd_ready, bus.busy, bus.rsp_valid, bus.PSEL}), 64'(4'b1000));
        repeat (3) @(negedge clk);
        chk("rst_rsp_none", 64'(rsp_q.size()), 64'(0));
        forced_waits = -1;
        run_burst(1'b0, 7'h30, 7'd3, -1, 0);
        run_burst(1'b1, 7'h7F, 7'd1, 0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
